// File: rtl/pulse_stretcher_pkg.sv
// Shared 500 Hz timing constants and state encoding for the pulse stretcher.
package pulse_stretcher_pkg;

    localparam int CLK_IN_HZ = 500;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pulse_stretcher_sat_counter.sv
// Up/down saturating request counter with synchronous clear and sticky overflow.
// Simultaneous inc and dec cancel; inc at MAX sets ovf instead of counting.
module pulse_stretcher_sat_counter #(
    parameter int MAX = 7,
    parameter int W   = 3
) (
    input  logic         clk_in,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         ovf
);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (inc && !dec) begin
            if (cnt == W'(MAX))
                ovf <= 1'b1;
            else
                cnt <= cnt + W'(1);
        end else if (dec && !inc && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches one-cycle strobes into HIGH_TICKS-wide pulses separated by GAP_TICKS low,
// queueing strobes that arrive while busy (saturating at MAX_PEND).
module pulse_stretcher #(
    parameter int HIGH_TICKS = 5,
    parameter int GAP_TICKS  = 5,
    parameter int MAX_PEND   = 7,
    parameter int PEND_W     = 3
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              D_in,
    input  logic              clear,
    output logic              D_out,
    output logic              busy,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              overflow
);

    import pulse_stretcher_pkg::*;

    localparam int T_MAX  = max_int(HIGH_TICKS, GAP_TICKS);
    localparam int TCNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam logic [TCNT_W-1:0] HIGH_LD = TCNT_W'(HIGH_TICKS - 1);
    localparam logic [TCNT_W-1:0] GAP_LD  = TCNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    state_t              state, state_nxt;
    logic [TCNT_W-1:0]   tcnt, tcnt_nxt;
    logic                d_out_nxt;
    logic                start, expire;
    logic                pend_avail, req, inc, dec;

    // A clear on this edge hides the queue, so only D_in can trigger a start.
    assign pend_avail = (pend_cnt != '0) && !clear;
    assign req        = D_in || pend_avail;
    assign dec        = start && pend_avail;
    assign inc        = D_in && !(start && !pend_avail);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            tcnt  <= '0;
            D_out <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            tcnt  <= tcnt_nxt;
            D_out <= d_out_nxt;
            busy  <= (state_nxt != ST_IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        tcnt_nxt  = tcnt;
        d_out_nxt = D_out;
        start     = 1'b0;
        expire    = 1'b0;
        case (state)
            ST_IDLE: start = req;
            ST_HIGH: begin
                if (tcnt == '0) begin
                    if (GAP_TICKS > 0) begin
                        state_nxt = ST_GAP;
                        tcnt_nxt  = GAP_LD;
                        d_out_nxt = 1'b0;
                    end else begin
                        expire = 1'b1;
                    end
                end else begin
                    tcnt_nxt = tcnt - TCNT_W'(1);
                end
            end
            ST_GAP: begin
                if (tcnt == '0)
                    expire = 1'b1;
                else
                    tcnt_nxt = tcnt - TCNT_W'(1);
            end
            default: begin
                state_nxt = ST_IDLE;
                d_out_nxt = 1'b0;
            end
        endcase
        // With a zero gap, HIGH expiry doubles as GAP expiry so D_out can stay high.
        if (expire) begin
            if (req) begin
                start = 1'b1;
            end else begin
                state_nxt = ST_IDLE;
                d_out_nxt = 1'b0;
            end
        end
        if (start) begin
            state_nxt = ST_HIGH;
            tcnt_nxt  = HIGH_LD;
            d_out_nxt = 1'b1;
        end
    end

    pulse_stretcher_sat_counter #(
        .MAX (MAX_PEND),
        .W   (PEND_W)
    ) u_pend (
        .clk_in (clk_in),
        .reset  (reset),
        .clr    (clear),
        .inc    (inc),
        .dec    (dec),
        .cnt    (pend_cnt),
        .ovf    (overflow)
    );

endmodule
